// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet-granular AXI-stream arbiter.
package axis_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        PASS = 1'b1
    } arb_state_t;

    localparam int FORCED_CNT_W = 16;

    // Index width that never collapses to zero bits for tiny N.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_packet_arbiter_rr_pick.sv
// Rotating priority encoder: first asserted request at or above ptr, wrapping at N.
module rr_pick
    import axis_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest match wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr) + k) % N);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Round-robin packet arbiter: holds a grant from first beat to tlast, forces tlast
// after MAX_BEATS beats, and drives the shared stream through one output register.
module axis_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter int N_IN      = 4,
    parameter int DWIDTH    = 24,
    parameter int MAX_BEATS = 256
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_IN*DWIDTH-1:0]   in_data,
    input  logic [N_IN-1:0]          in_valid,
    input  logic [N_IN-1:0]          in_last,
    output logic [N_IN-1:0]          in_ready,
    output logic [DWIDTH-1:0]        out_data,
    output logic                     out_valid,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic [$clog2(N_IN)-1:0]  out_src,
    output logic [FORCED_CNT_W-1:0]  forced_count
);

    localparam int IW = clog2_min1(N_IN);
    localparam int BW = $clog2(MAX_BEATS + 1);
    localparam logic [BW-1:0] LIMIT_CNT = BW'(MAX_BEATS - 1);

    arb_state_t               state_q, state_d;
    logic [IW-1:0]            grant_q, grant_d;
    logic [IW-1:0]            rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]            beat_cnt_q, beat_cnt_d;
    logic [DWIDTH-1:0]        out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;
    logic [IW-1:0]            out_src_q, out_src_d;
    logic [FORCED_CNT_W-1:0]  forced_cnt_q, forced_cnt_d;

    logic              pick_found;
    logic [IW-1:0]     pick_idx;
    logic              out_free;
    logic [DWIDTH-1:0] sel_data;
    logic              sel_valid;
    logic              sel_last;
    logic              accept;
    logic              at_limit;
    logic              beat_last;

    rr_pick #(
        .N  (N_IN),
        .IW (IW)
    ) u_rr_pick (
        .req   (in_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign out_free = !out_valid_q || out_ready;

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        in_ready  = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (grant_q == IW'(i)) begin
                sel_data  = in_data[i*DWIDTH +: DWIDTH];
                sel_valid = in_valid[i];
                sel_last  = in_last[i];
                in_ready[i] = (state_q == PASS) && out_free;
            end
        end
    end

    assign accept    = (state_q == PASS) && out_free && sel_valid;
    assign at_limit  = (beat_cnt_q == LIMIT_CNT);
    assign beat_last = sel_last || at_limit;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        beat_cnt_d   = beat_cnt_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_src_d    = out_src_q;
        forced_cnt_d = forced_cnt_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ARB: begin
                // Arbitration may overlap a stalled final beat; in_ready still gates on out_free.
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = PASS;
                end
            end
            PASS: begin
                if (accept) begin
                    out_data_d  = sel_data;
                    out_valid_d = 1'b1;
                    out_last_d  = beat_last;
                    out_src_d   = grant_q;
                    if (beat_last) begin
                        beat_cnt_d = '0;
                        rr_ptr_d   = (grant_q == IW'(N_IN - 1)) ? '0 : grant_q + 1'b1;
                        state_d    = ARB;
                        if (!sel_last && (forced_cnt_q != '1)) begin
                            forced_cnt_d = forced_cnt_q + 1'b1;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ARB;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            beat_cnt_q   <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_src_q    <= '0;
            forced_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            beat_cnt_q   <= beat_cnt_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_src_q    <= out_src_d;
            forced_cnt_q <= forced_cnt_d;
        end
    end

    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign out_last     = out_last_q;
    assign out_src      = out_src_q;
    assign forced_count = forced_cnt_q;

endmodule
